// File: rtl/defines_pkg.sv
// Shared types and widths for the dnn aggregation stage.
package defines_pkg;

    localparam int Y_W    = 13;
    localparam int AGGR_W = 15;

    typedef enum logic [2:0] {
        IDLE,
        L1_S0,
        XCHG_S0,
        L1_S1,
        XCHG_S1,
        FINAL_OUT,
        DONE
    } dnn_state_t;

    function automatic logic signed [AGGR_W-1:0] sext(input logic signed [Y_W-1:0] v);
        return {{(AGGR_W-Y_W){v[Y_W-1]}}, v};
    endfunction

endpackage

// File: rtl/dnn_aggr_add4.sv
// Four parallel sign-extending 13+13->15 bit adders.
module dnn_aggr_add4
    import defines_pkg::*;
(
    input  logic signed [Y_W-1:0]    a0,
    input  logic signed [Y_W-1:0]    a1,
    input  logic signed [Y_W-1:0]    a2,
    input  logic signed [Y_W-1:0]    a3,
    input  logic signed [Y_W-1:0]    b0,
    input  logic signed [Y_W-1:0]    b1,
    input  logic signed [Y_W-1:0]    b2,
    input  logic signed [Y_W-1:0]    b3,
    output logic signed [AGGR_W-1:0] s0,
    output logic signed [AGGR_W-1:0] s1,
    output logic signed [AGGR_W-1:0] s2,
    output logic signed [AGGR_W-1:0] s3
);

    always_comb begin
        s0 = sext(a0) + sext(b0);
        s1 = sext(a1) + sext(b1);
        s2 = sext(a2) + sext(b2);
        s3 = sext(a3) + sext(b3);
    end

endmodule

// File: rtl/dnn_aggr.sv
// Two-sample hidden-layer aggregation with a peer node.
// Optional peer-exchange timeout enabled by DNN_AGGR_TIMEOUT_EN.
module dnn_aggr
    import defines_pkg::*;
#(
    parameter int PEER_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [Y_W-1:0]    y4_relu,
    input  logic signed [Y_W-1:0]    y5_relu,
    input  logic signed [Y_W-1:0]    y6_relu,
    input  logic signed [Y_W-1:0]    y7_relu,
    input  logic                     peer_valid,
    input  logic signed [Y_W-1:0]    peer_y4,
    input  logic signed [Y_W-1:0]    peer_y5,
    input  logic signed [Y_W-1:0]    peer_y6,
    input  logic signed [Y_W-1:0]    peer_y7,
    input  logic                     out0_ready,
    input  logic                     out1_ready,
    output logic                     peer_ready,
    output logic                     sample_sel,
    output dnn_state_t               dnn_state,
    output logic signed [AGGR_W-1:0] y4_n0_aggr,
    output logic signed [AGGR_W-1:0] y5_n0_aggr,
    output logic signed [AGGR_W-1:0] y6_n0_aggr,
    output logic signed [AGGR_W-1:0] y7_n0_aggr,
    output logic signed [AGGR_W-1:0] y4_n1_aggr,
    output logic signed [AGGR_W-1:0] y5_n1_aggr,
    output logic signed [AGGR_W-1:0] y6_n1_aggr,
    output logic signed [AGGR_W-1:0] y7_n1_aggr,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err
);

    dnn_state_t state_q, state_d;
    logic       l1_cnt_q;
    logic       capture;
    logic       in_xchg;
    logic       xfer;
    logic       to_fire;
    logic       advance;

    logic signed [Y_W-1:0]    loc_q     [4];
    logic signed [Y_W-1:0]    peer_op   [4];
    logic signed [AGGR_W-1:0] sum       [4];
    logic signed [AGGR_W-1:0] aggr_n0_q [4];
    logic signed [AGGR_W-1:0] aggr_n1_q [4];

    assign in_xchg = (state_q == XCHG_S0) || (state_q == XCHG_S1);
    assign xfer    = in_xchg && peer_valid;
    assign advance = xfer || to_fire;

`ifdef DNN_AGGR_TIMEOUT_EN
    localparam int TO_W = (PEER_TIMEOUT > 1) ? $clog2(PEER_TIMEOUT) : 1;

    logic [TO_W-1:0] to_cnt_q;
    logic            to_err_q;

    assign to_fire     = in_xchg && !peer_valid && (to_cnt_q == TO_W'(PEER_TIMEOUT - 1));
    assign timeout_err = to_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= (in_xchg && !advance) ? to_cnt_q + 1'b1 : '0;
            if (state_q == IDLE && start)
                to_err_q <= 1'b0;
            else if (to_fire)
                to_err_q <= 1'b1;
        end
    end
`else
    assign to_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // A timed-out exchange adds zero so the aggregate keeps the local value only.
    always_comb begin
        peer_op[0] = xfer ? peer_y4 : '0;
        peer_op[1] = xfer ? peer_y5 : '0;
        peer_op[2] = xfer ? peer_y6 : '0;
        peer_op[3] = xfer ? peer_y7 : '0;
    end

    dnn_aggr_add4 u_add4 (
        .a0 (loc_q[0]),   .a1 (loc_q[1]),   .a2 (loc_q[2]),   .a3 (loc_q[3]),
        .b0 (peer_op[0]), .b1 (peer_op[1]), .b2 (peer_op[2]), .b3 (peer_op[3]),
        .s0 (sum[0]),     .s1 (sum[1]),     .s2 (sum[2]),     .s3 (sum[3])
    );

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE:      if (start) state_d = L1_S0;
            L1_S0:     if (l1_cnt_q) begin capture = 1'b1; state_d = XCHG_S0; end
            XCHG_S0:   if (advance) state_d = L1_S1;
            L1_S1:     if (l1_cnt_q) begin capture = 1'b1; state_d = XCHG_S1; end
            XCHG_S1:   if (advance) state_d = FINAL_OUT;
            FINAL_OUT: if (out0_ready && out1_ready) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            l1_cnt_q  <= 1'b0;
            loc_q     <= '{default: '0};
            aggr_n0_q <= '{default: '0};
            aggr_n1_q <= '{default: '0};
        end else begin
            state_q  <= state_d;
            l1_cnt_q <= ((state_q == L1_S0) || (state_q == L1_S1)) ? ~l1_cnt_q : 1'b0;
            if (capture) begin
                loc_q[0] <= y4_relu;
                loc_q[1] <= y5_relu;
                loc_q[2] <= y6_relu;
                loc_q[3] <= y7_relu;
            end
            if (state_q == IDLE && start) begin
                aggr_n0_q <= '{default: '0};
                aggr_n1_q <= '{default: '0};
            end else if (advance && state_q == XCHG_S0) begin
                aggr_n0_q <= sum;
            end else if (advance && state_q == XCHG_S1) begin
                aggr_n1_q <= sum;
            end
        end
    end

    assign dnn_state  = state_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign peer_ready = in_xchg;
    assign sample_sel = (state_q == L1_S1) || (state_q == XCHG_S1);

    assign y4_n0_aggr = aggr_n0_q[0];
    assign y5_n0_aggr = aggr_n0_q[1];
    assign y6_n0_aggr = aggr_n0_q[2];
    assign y7_n0_aggr = aggr_n0_q[3];
    assign y4_n1_aggr = aggr_n1_q[0];
    assign y5_n1_aggr = aggr_n1_q[1];
    assign y6_n1_aggr = aggr_n1_q[2];
    assign y7_n1_aggr = aggr_n1_q[3];

endmodule
